multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control unit for the multicycle RV32I core: a Moore state machine plus ALU decoder that steps each instruction through fetch, decode, execute, memory and writeback cycles. It sits directly upstream of the datapath. It consumes the datapath's instruction register and ALU zero flag, and drives every datapath enable and mux select. It also keeps a retired-instruction counter and flags unsupported opcodes.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clock clk
- instr  in  32  current instruction register contents from the datapath
- zero  in  1  ALU result == 0 from the datapath, valid in the cycle it is sampled
- mem_write  out  1  data memory write enable
- reg_write  out  1  register file write enable
- ir_write  out  1  instruction register load enable
- pc_write  out  1  PC load enable
- instruction_or_data  out  1  memory address select: 0 = PC, 1 = result
- result_src  out  2  00 = alu_out, 01 = memory data, 10 = alu_result
- alu_src_a  out  2  00 = PC, 01 = rs1, 10 = zero constant
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate, 11 = zero constant
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- halted  out  1  high while in ERROR
- instr_retired  out  32  count of completed instructions

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ERROR.
- FETCH: ir_write=1, instruction_or_data=0, src_a=00, src_b=01, alu add, result_src=10, pc_update=1. Next state is DECODE.
- DECODE: all enables 0; src_a=00, src_b=10, alu add (branch target precompute). Next state depends on instr[6:0]:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → ERROR
- MEMADR: src_a=01, src_b=10, alu add. Next state is MEMREAD if opcode = lw, else MEMWRITE.
- MEMREAD: instruction_or_data=1, result_src=00. Next state is MEMWB.
- MEMWB: reg_write=1, result_src=01. Next state is FETCH.
- MEMWRITE: mem_write=1, instruction_or_data=1, result_src=00. Next state is FETCH.
- EXECR: src_a=01, src_b=00, alu_op=funct. Next state is ALUWB.
- EXECI: src_a=01, src_b=10, alu_op=funct. Next state is ALUWB.
- ALUWB: reg_write=1, result_src=00. Next state is FETCH.
- BEQ: src_a=01, src_b=00, alu sub, branch=1, result_src=00. Next state is FETCH.
- JAL: src_a=00, src_b=01, alu add, result_src=00, pc_update=1. Next state is ALUWB.
- ERROR: all enables 0, halted=1. The FSM stays in ERROR until reset.
- pc_write = pc_update | (branch & zero).
- ALU decoder:
  - alu_op add → 000; sub → 001.
  - funct, by funct3:
    - 000: sub if instr[30] & instr[5], else add.
    - 010: 101.
    - 110: 011.
    - 111: 010.
    - any other funct3: 000, not an error.
- instr_retired increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps from 0xFFFFFFFF to 0.

## Timing
- The state register and instr_retired reset asynchronously to FETCH and 0.
- While reset is high, mem_write, reg_write, ir_write and pc_write are forced to 0. Mux selects hold their FETCH values. halted=0.
- All outputs are combinational from state and instr, except that pc_write also depends on zero in BEQ.
- Cycle counts: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, each including FETCH and DECODE.
- Deasserting reset: the first rising edge executes FETCH.
- Asserting reset mid-instruction abandons the instruction immediately: no counter increment, and write enables drop in the same cycle.
- instr_retired updates on the same edge that enters FETCH. The new value is visible in FETCH.

## Configuration
- CTRL_JAL_EN defined: opcode 1101111 decodes to JAL as described.
- CTRL_JAL_EN undefined: the JAL state is absent, and opcode 1101111 goes from DECODE to ERROR.

## Structure
- Package ctrl_pkg holds:
  - the state enum
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - alu_control codes
  - result_src, alu_src_a and alu_src_b encodings
  - the 2-bit alu_op enum (add, sub, funct)
- Sub-module alu_decoder is combinational. It maps alu_op, funct3, instr[30] and instr[5] to alu_control.

## Test plan
- lw x5,8(x1) (instr=0x0080A283): after reset, states FETCH→DECODE→MEMADR→MEMREAD→MEMWB→FETCH. reg_write=1 only in MEMWB with result_src=01. instr_retired 0→1.
- sub x3,x1,x2 (0x402081B3): EXECR drives alu_control=001, src_a=01, src_b=00. ALUWB drives reg_write=1. Four cycles total.
- beq x0,x0 (0x00000063): with zero=1 in BEQ, pc_write=1. Repeating with zero=0 gives pc_write=0 in BEQ. Three cycles each, and the counter increments both times.
- Illegal opcode 0xFFFFFFFF: DECODE→ERROR, halted=1, and all enables stay 0 for 10 cycles. Asserting reset returns to FETCH with halted=0.
- jal (0x0000006F): with CTRL_JAL_EN defined, FETCH→DECODE→JAL→ALUWB with pc_write=1 in JAL. Without the macro, the FSM goes to ERROR.
- Reset asserted in MEMREAD: the state is FETCH asynchronously, no counter change, write enables are 0 during reset. Also preload instr_retired to 0xFFFFFFFF via 2^32−1 completions (or force) and check the next increment gives 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the multicycle RV32I control unit
// CTRL_JAL_EN adds the JAL state to the state enum.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BEQ,
`ifdef CTRL_JAL_EN
      S_JAL,
`endif
      S_ERROR
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALU_OUT    = 2'b00;
   localparam logic [1:0] RES_MEM        = 2'b01;
   localparam logic [1:0] RES_ALU_RESULT = 2'b10;

   localparam logic [1:0] SRCA_PC   = 2'b00;
   localparam logic [1:0] SRCA_RS1  = 2'b01;
   localparam logic [1:0] SRCA_ZERO = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_ZERO = 2'b11;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational mapping of alu_op and instruction fields to alu_control
module alu_decoder
   import ctrl_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       op_5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // only R-type (op_5 set) may subtract; addi ignores imm bit 30
               3'b000:  alu_control = (funct7_5 & op_5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32I main control FSM, ALU decode and retire counter
// Optional JAL support is enabled by defining CTRL_JAL_EN.
module multicycle_control
   import ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        zero,
   output logic        mem_write,
   output logic        reg_write,
   output logic        ir_write,
   output logic        pc_write,
   output logic        instruction_or_data,
   output logic [1:0]  result_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_control,
   output logic        halted,
   output logic [31:0] instr_retired
);

   state_t      state;
   state_t      next_state;
   alu_op_t     alu_op;
   logic        mem_write_raw;
   logic        reg_write_raw;
   logic        ir_write_raw;
   logic        pc_update;
   logic        branch;
   logic        retire;
   logic [31:0] retired_q;
   logic [6:0]  opcode;
   logic        unused_instr;

   assign opcode       = instr[6:0];
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_FETCH:  next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_R:         next_state = S_EXECR;
               OP_I:         next_state = S_EXECI;
               OP_BEQ:       next_state = S_BEQ;
`ifdef CTRL_JAL_EN
               OP_JAL:       next_state = S_JAL;
`endif
               default:      next_state = S_ERROR;
            endcase
         end
         S_MEMADR:   next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  next_state = S_MEMWB;
         S_MEMWB:    next_state = S_FETCH;
         S_MEMWRITE: next_state = S_FETCH;
         S_EXECR:    next_state = S_ALUWB;
         S_EXECI:    next_state = S_ALUWB;
         S_ALUWB:    next_state = S_FETCH;
         S_BEQ:      next_state = S_FETCH;
`ifdef CTRL_JAL_EN
         S_JAL:      next_state = S_ALUWB;
`endif
         S_ERROR:    next_state = S_ERROR;
         default:    next_state = S_ERROR;
      endcase
   end

   always_comb begin
      mem_write_raw       = 1'b0;
      reg_write_raw       = 1'b0;
      ir_write_raw        = 1'b0;
      pc_update           = 1'b0;
      branch              = 1'b0;
      instruction_or_data = 1'b0;
      result_src          = RES_ALU_OUT;
      alu_src_a           = SRCA_PC;
      alu_src_b           = SRCB_RS2;
      alu_op              = ALUOP_ADD;
      halted              = 1'b0;
      case (state)
         S_FETCH: begin
            ir_write_raw = 1'b1;
            pc_update    = 1'b1;
            alu_src_b    = SRCB_FOUR;
            result_src   = RES_ALU_RESULT;
         end
         S_DECODE: alu_src_b = SRCB_IMM;
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: instruction_or_data = 1'b1;
         S_MEMWB: begin
            reg_write_raw = 1'b1;
            result_src    = RES_MEM;
         end
         S_MEMWRITE: begin
            mem_write_raw       = 1'b1;
            instruction_or_data = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_FUNCT;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: reg_write_raw = 1'b1;
         S_BEQ: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_SUB;
            branch    = 1'b1;
         end
`ifdef CTRL_JAL_EN
         S_JAL: begin
            alu_src_b = SRCB_FOUR;
            pc_update = 1'b1;
         end
`endif
         S_ERROR: halted = 1'b1;
         default: halted = 1'b1;
      endcase
   end

   // reset gates every write strobe so an abandoned instruction cannot commit
   assign mem_write = mem_write_raw & ~reset;
   assign reg_write = reg_write_raw & ~reset;
   assign ir_write  = ir_write_raw & ~reset;
   assign pc_write  = (pc_update | (branch & zero)) & ~reset;

   assign retire = (state == S_MEMWB) || (state == S_MEMWRITE) ||
                   (state == S_ALUWB) || (state == S_BEQ);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       retired_q <= 32'd0;
      else if (retire) retired_q <= retired_q + 32'd1;
   end

   assign instr_retired = retired_q;

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (instr[14:12]),
      .funct7_5    (instr[30]),
      .op_5        (instr[5]),
      .alu_control (alu_control)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
// Expectations for opcode 1101111 follow CTRL_JAL_EN.
module tb_multicycle_control;

   localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMREAD = 3, T_MEMWB = 4;
   localparam int T_MEMWRITE = 5, T_EXECR = 6, T_EXECI = 7, T_ALUWB = 8, T_BEQ = 9;
   localparam int T_JAL = 10, T_ERROR = 11, T_RESET = 12;

   typedef struct {
      logic [46:0] v;
      logic [46:0] m;
      string       nm;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [31:0] instr;
   logic        zero;
   logic        mem_write, reg_write, ir_write, pc_write, instruction_or_data, halted;
   logic [1:0]  result_src, alu_src_a, alu_src_b;
   logic [2:0]  alu_control;
   logic [31:0] instr_retired;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] r = 32'd0;

   multicycle_control dut (
      .clk                 (clk),
      .reset               (reset),
      .instr               (instr),
      .zero                (zero),
      .mem_write           (mem_write),
      .reg_write           (reg_write),
      .ir_write            (ir_write),
      .pc_write            (pc_write),
      .instruction_or_data (instruction_or_data),
      .result_src          (result_src),
      .alu_src_a           (alu_src_a),
      .alu_src_b           (alu_src_b),
      .alu_control         (alu_control),
      .halted              (halted),
      .instr_retired       (instr_retired)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // layout {mem_write, reg_write, ir_write, pc_write, iod, result_src, src_a, src_b, alu, halted, retired}
   function automatic exp_t mk(string nm, logic [3:0] en, logic h,
                               logic iod, bit iod_c, logic [1:0] rs, bit rs_c,
                               logic [1:0] sa, bit sa_c, logic [1:0] sb, bit sb_c,
                               logic [2:0] alu, bit alu_c, logic [31:0] ret);
      exp_t e;
      e.v  = {en, iod, rs, sa, sb, alu, h, ret};
      e.m  = {4'hF, iod_c, {2{rs_c}}, {2{sa_c}}, {2{sb_c}}, {3{alu_c}}, 1'b1, 32'hFFFF_FFFF};
      e.nm = nm;
      return e;
   endfunction

   function automatic exp_t expect_state(int s, string nm, logic [2:0] alu, logic z, logic [31:0] ret);
      case (s)
         T_FETCH:    return mk({nm, "/fetch"},    4'b0011, 0, 0, 1, 2'b10, 1, 2'b00, 1, 2'b01, 1, 3'b000, 1, ret);
         T_DECODE:   return mk({nm, "/decode"},   4'b0000, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b10, 1, 3'b000, 1, ret);
         T_MEMADR:   return mk({nm, "/memadr"},   4'b0000, 0, 0, 0, 2'b00, 0, 2'b01, 1, 2'b10, 1, 3'b000, 1, ret);
         T_MEMREAD:  return mk({nm, "/memread"},  4'b0000, 0, 1, 1, 2'b00, 1, 2'b00, 0, 2'b00, 0, 3'b000, 0, ret);
         T_MEMWB:    return mk({nm, "/memwb"},    4'b0100, 0, 0, 0, 2'b01, 1, 2'b00, 0, 2'b00, 0, 3'b000, 0, ret);
         T_MEMWRITE: return mk({nm, "/memwrite"}, 4'b1000, 0, 1, 1, 2'b00, 1, 2'b00, 0, 2'b00, 0, 3'b000, 0, ret);
         T_EXECR:    return mk({nm, "/execr"},    4'b0000, 0, 0, 0, 2'b00, 0, 2'b01, 1, 2'b00, 1, alu,    1, ret);
         T_EXECI:    return mk({nm, "/execi"},    4'b0000, 0, 0, 0, 2'b00, 0, 2'b01, 1, 2'b10, 1, alu,    1, ret);
         T_ALUWB:    return mk({nm, "/aluwb"},    4'b0100, 0, 0, 0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 3'b000, 0, ret);
         T_BEQ:      return mk({nm, "/beq"},      {3'b000, z}, 0, 0, 0, 2'b00, 1, 2'b01, 1, 2'b00, 1, 3'b001, 1, ret);
         T_JAL:      return mk({nm, "/jal"},      4'b0001, 0, 0, 0, 2'b00, 1, 2'b00, 1, 2'b01, 1, 3'b000, 1, ret);
         T_ERROR:    return mk({nm, "/error"},    4'b0000, 1, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, ret);
         default:    return mk({nm, "/reset"},    4'b0000, 0, 0, 1, 2'b10, 1, 2'b00, 1, 2'b01, 1, 3'b000, 1, 32'd0);
      endcase
   endfunction

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t        e;
         logic [46:0] act;
         e   = sb_q.pop_front();
         act = {mem_write, reg_write, ir_write, pc_write, instruction_or_data, result_src,
                alu_src_a, alu_src_b, alu_control, halted, instr_retired};
         checks++;
         if ((act & e.m) !== (e.v & e.m)) begin
            errors++;
            $display("FAIL %s: got %h required %h (mask %h)", e.nm, act, e.v & e.m, e.m);
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sb_q.push_back(expect_state(T_RESET, "reset", 3'b000, 1'b0, 32'd0));
      sb_q.push_back(expect_state(T_RESET, "reset", 3'b000, 1'b0, 32'd0));
      cycle();
      cycle();
      reset = 1'b0;
      r = 32'd0;
   endtask

   // state order: FETCH, DECODE, s2, s3, then s4 for every later cycle
   task automatic issue(input string nm, input logic [31:0] ins, input logic z,
                        input logic [2:0] alu, input int n, input int s2,
                        input int s3, input int s4, input bit retires);
      instr = ins;
      zero  = z;
      for (int i = 0; i < n; i++) begin
         int s;
         s = (i == 0) ? T_FETCH : (i == 1) ? T_DECODE : (i == 2) ? s2 : (i == 3) ? s3 : s4;
         sb_q.push_back(expect_state(s, nm, alu, z, r));
      end
      repeat (n) cycle();
      if (retires) r = r + 32'd1;
   endtask

   initial begin
      reset = 1'b1;
      instr = 32'd0;
      zero  = 1'b0;
      cycle();
      do_reset();

      issue("lw",   32'h0080A283, 0, 3'b000, 5, T_MEMADR, T_MEMREAD, T_MEMWB, 1);
      issue("sw",   32'h0050A423, 0, 3'b000, 4, T_MEMADR, T_MEMWRITE, T_MEMWRITE, 1);
      issue("sub",  32'h402081B3, 0, 3'b001, 4, T_EXECR, T_ALUWB, T_ALUWB, 1);
      issue("add",  32'h002081B3, 0, 3'b000, 4, T_EXECR, T_ALUWB, T_ALUWB, 1);
      issue("and",  32'h0020F1B3, 0, 3'b010, 4, T_EXECR, T_ALUWB, T_ALUWB, 1);
      issue("or",   32'h0020E1B3, 0, 3'b011, 4, T_EXECR, T_ALUWB, T_ALUWB, 1);
      issue("slt",  32'h0020A1B3, 0, 3'b101, 4, T_EXECR, T_ALUWB, T_ALUWB, 1);
      issue("sll",  32'h002091B3, 0, 3'b000, 4, T_EXECR, T_ALUWB, T_ALUWB, 1);
      issue("addi", 32'h00500093, 0, 3'b000, 4, T_EXECI, T_ALUWB, T_ALUWB, 1);
      issue("addi_b30", 32'h40008093, 0, 3'b000, 4, T_EXECI, T_ALUWB, T_ALUWB, 1);
      issue("andi", 32'h0FF0F093, 0, 3'b010, 4, T_EXECI, T_ALUWB, T_ALUWB, 1);
      issue("beq_z1", 32'h00000063, 1, 3'b001, 3, T_BEQ, T_BEQ, T_BEQ, 1);
      issue("beq_z0", 32'h00000063, 0, 3'b001, 3, T_BEQ, T_BEQ, T_BEQ, 1);
`ifdef CTRL_JAL_EN
      issue("jal",  32'h0000006F, 0, 3'b000, 4, T_JAL, T_ALUWB, T_ALUWB, 1);
`else
      issue("jal_off", 32'h0000006F, 0, 3'b000, 4, T_ERROR, T_ERROR, T_ERROR, 0);
      do_reset();
`endif
      issue("sw2",  32'h0050A423, 0, 3'b000, 4, T_MEMADR, T_MEMWRITE, T_MEMWRITE, 1);

      issue("lw_abort", 32'h0080A283, 0, 3'b000, 3, T_MEMADR, T_MEMADR, T_MEMADR, 0);
      do_reset();

      issue("illegal", 32'hFFFF_FFFF, 0, 3'b000, 12, T_ERROR, T_ERROR, T_ERROR, 0);
      do_reset();

      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      r = 32'hFFFF_FFFF;
      issue("beq_wrap", 32'h00000063, 0, 3'b001, 3, T_BEQ, T_BEQ, T_BEQ, 1);
      sb_q.push_back(expect_state(T_FETCH, "after_wrap", 3'b000, 1'b0, r));
      cycle();

      for (int i = 0; i < 20 && sb_q.size() > 0; i++) cycle();
      if (sb_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left, required 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
